// File: rtl/iic_cfg_seq_if.sv
// Transaction bus between the configuration sequencer (master) and the I2C byte driver (slave).
interface iic_cfg_seq_if;
   logic        start_en;
   logic        wr_rd_flag;
   logic [7:0]  i2c_device_addr;
   logic [15:0] register;
   logic [7:0]  data_byte;
   logic        busy;
   logic        err;
   logic [7:0]  rd_data;

   modport master (
      output start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
      input  busy, err, rd_data
   );

   modport slave (
      input  start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
      output busy, err, rd_data
   );
endinterface

// File: rtl/iic_cfg_seq.sv
// iic_cfg_seq: walks a configuration table, issuing one I2C driver transaction per entry with retries.
// Define IIC_CFG_VERIFY_EN to read back every successful write and compare it with the written byte.
module iic_cfg_seq #(
   parameter int N_ENTRIES    = 16,
   parameter int MAX_RETRY    = 3,
   parameter int GAP_CYCLES   = 100,
   parameter int BUSY_TIMEOUT = 4095
) (
   input  logic          clk_i,
   input  logic          rst,
   input  logic          cfg_start,
   output logic [7:0]    tbl_addr,
   input  logic [32:0]   tbl_data,
   output logic          cfg_busy,
   output logic          cfg_done,
   output logic          cfg_fail,
   output logic [7:0]    fail_idx,
   output logic [7:0]    last_rd,
   iic_cfg_seq_if.master drv
);

   typedef enum logic [3:0] {
      IDLE, FETCH, LOAD, START, WAIT_HI, WAIT_LO, CHECK, GAP, DONE, FAIL
`ifdef IIC_CFG_VERIFY_EN
      , V_START, V_HI, V_LO, V_CHECK
`endif
   } state_t;

   state_t      state_q;
   logic        start_q;
   logic [7:0]  idx_q;
   logic [31:0] retry_q;
   logic [31:0] tmo_q;
   logic [31:0] gap_q;
   logic        err_seen_q;
   logic [7:0]  tbl_addr_q;
   logic        wr_rd_q;
   logic [7:0]  dev_q;
   logic [15:0] reg_q;
   logic [7:0]  data_q;
   logic        start_en_q;
   logic        busy_q;
   logic        done_q;
   logic        fail_q;
   logic [7:0]  fail_idx_q;
   logic [7:0]  last_rd_q;

   logic   start_rise_d;
   logic   last_entry_d;
   logic   attempt_ok_d;
   state_t wait_hi_d;
   state_t wait_lo_d;
   state_t check_d;

   assign start_rise_d = cfg_start & ~start_q;
   assign last_entry_d = (idx_q == 8'(N_ENTRIES - 1));

   // The write and verify-read phases share handshake code; these pick which phase's states follow.
   always_comb begin
      wait_hi_d    = WAIT_HI;
      wait_lo_d    = WAIT_LO;
      check_d      = CHECK;
      attempt_ok_d = ~err_seen_q;
`ifdef IIC_CFG_VERIFY_EN
      if (state_q == V_START || state_q == V_HI || state_q == V_LO || state_q == V_CHECK) begin
         wait_hi_d    = V_HI;
         wait_lo_d    = V_LO;
         check_d      = V_CHECK;
         attempt_ok_d = ~err_seen_q && (drv.rd_data == data_q);
      end
`endif
   end

   // start_q resets high so a cfg_start level already present at reset release is not seen as an edge.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= 1'b1;
         idx_q      <= 8'd0;
         retry_q    <= 32'd0;
         tmo_q      <= 32'd0;
         gap_q      <= 32'd0;
         err_seen_q <= 1'b0;
         tbl_addr_q <= 8'd0;
         wr_rd_q    <= 1'b0;
         dev_q      <= 8'd0;
         reg_q      <= 16'd0;
         data_q     <= 8'd0;
         start_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         fail_idx_q <= 8'd0;
         last_rd_q  <= 8'd0;
      end else begin
         start_q    <= cfg_start;
         start_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_rise_d) begin
                  idx_q      <= 8'd0;
                  retry_q    <= 32'd0;
                  tbl_addr_q <= 8'd0;
                  done_q     <= 1'b0;
                  fail_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            FETCH: state_q <= LOAD;
            LOAD: begin
               {wr_rd_q, dev_q, reg_q, data_q} <= tbl_data;
               state_q <= START;
            end
`ifdef IIC_CFG_VERIFY_EN
            START, V_START: begin
`else
            START: begin
`endif
               if (!drv.busy) begin
                  start_en_q <= 1'b1;
                  tmo_q      <= 32'd0;
                  err_seen_q <= 1'b0;
                  state_q    <= wait_hi_d;
               end
            end
`ifdef IIC_CFG_VERIFY_EN
            WAIT_HI, V_HI: begin
`else
            WAIT_HI: begin
`endif
               err_seen_q <= err_seen_q | drv.err;
               if (drv.busy) begin
                  state_q <= wait_lo_d;
               end else if (tmo_q >= 32'(BUSY_TIMEOUT)) begin
                  err_seen_q <= 1'b1;
                  state_q    <= check_d;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
`ifdef IIC_CFG_VERIFY_EN
            WAIT_LO, V_LO: begin
`else
            WAIT_LO: begin
`endif
               err_seen_q <= err_seen_q | drv.err;
               if (!drv.busy) state_q <= check_d;
            end
`ifdef IIC_CFG_VERIFY_EN
            CHECK, V_CHECK: begin
`else
            CHECK: begin
`endif
               if (attempt_ok_d) begin
                  if (state_q == CHECK && wr_rd_q) last_rd_q <= drv.rd_data;
`ifdef IIC_CFG_VERIFY_EN
                  if (state_q == CHECK && !wr_rd_q) begin
                     wr_rd_q <= 1'b1;
                     state_q <= V_START;
                  end else
`endif
                  if (last_entry_d) begin
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_q + 8'd1;
                     retry_q <= 32'd0;
                     gap_q   <= 32'd0;
                     state_q <= GAP;
                  end
               end else if (retry_q < 32'(MAX_RETRY)) begin
                  retry_q <= retry_q + 32'd1;
                  gap_q   <= 32'd0;
                  state_q <= GAP;
               end else begin
                  fail_idx_q <= idx_q;
                  state_q    <= FAIL;
               end
            end
            GAP: begin
               if (gap_q + 32'd1 >= 32'(GAP_CYCLES)) begin
                  tbl_addr_q <= idx_q;
                  state_q    <= FETCH;
               end else begin
                  gap_q <= gap_q + 32'd1;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            FAIL: begin
               fail_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tbl_addr            = tbl_addr_q;
   assign cfg_busy            = busy_q;
   assign cfg_done            = done_q;
   assign cfg_fail            = fail_q;
   assign fail_idx            = fail_idx_q;
   assign last_rd             = last_rd_q;
   assign drv.start_en        = start_en_q;
   assign drv.wr_rd_flag      = wr_rd_q;
   assign drv.i2c_device_addr = dev_q;
   assign drv.register        = reg_q;
   assign drv.data_byte       = data_q;

endmodule
